// File: rtl/tm1638_pkg.sv
// Shared constants, FSM state type and timing helper for the TM1638 chain controller.
package tm1638_pkg;

  localparam logic [7:0] C_READ_KEYS    = 8'h42;
  localparam logic [7:0] C_WRITE_DISP   = 8'h40;
  localparam logic [7:0] C_SET_ADDR_0   = 8'hC0;
  localparam logic [7:0] C_DISPLAY_BASE = 8'h88;
  localparam logic [7:0] C_DISPLAY_OFF  = 8'h80;

  typedef enum logic [2:0] {
    S_GAP,
    S_KEYCMD,
    S_KEYRD,
    S_MODE,
    S_ADDR,
    S_CTRL
  } state_e;

  // Serial clock half-period in system clock cycles, rounded up, never below 1.
  function automatic int unsigned calc_hp(input int unsigned clk_mhz,
                                          input int unsigned sclk_khz);
    int unsigned v;
    v = (clk_mhz * 1000 + 2 * sclk_khz - 1) / (2 * sclk_khz);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/tm1638_shift_engine.sv
// Byte shifter for the TM1638 serial bus: LSB first, data changes on the falling
// edge of sio_clk, read data is captured on the cycle sio_clk rises.
module tm1638_shift_engine #(
  parameter int unsigned hp = 36
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       sio_clk,
  input  logic       sio_data_in,
  output logic       sio_data_out
);

  localparam int unsigned CW = (hp > 1) ? $clog2(hp) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(hp - 1);

  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic          high_q;
  logic [7:0]    tx_q;

  // Bit timing: hp cycles low, hp cycles high per bit, eight bits per byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      rx_byte      <= 8'h00;
      sio_clk      <= 1'b1;
      sio_data_out <= 1'b0;
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      high_q       <= 1'b0;
      tx_q         <= 8'h00;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy         <= 1'b1;
          sio_clk      <= 1'b0;
          sio_data_out <= tx_byte[0];
          tx_q         <= tx_byte;
          bit_q        <= 3'd0;
          high_q       <= 1'b0;
          cnt_q        <= '0;
        end
      end else if (cnt_q != CNT_LAST) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
        if (!high_q) begin
          sio_clk        <= 1'b1;
          high_q         <= 1'b1;
          rx_byte[bit_q] <= sio_data_in;
        end else if (bit_q == 3'd7) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          bit_q        <= bit_q + 3'd1;
          high_q       <= 1'b0;
          sio_clk      <= 1'b0;
          sio_data_out <= tx_q[bit_q + 3'd1];
        end
      end
    end
  end

endmodule

// File: rtl/tm1638_chain_controller.sv
// Round-robin controller for a chain of TM1638 LED&KEY boards sharing sio_clk/DIO.
// Optional key debounce is built when TM1638_KEY_DEBOUNCE_EN is defined.
module tm1638_chain_controller
  import tm1638_pkg::*;
#(
  parameter int unsigned clk_mhz    = 50,
  parameter int unsigned sclk_khz   = 700,
  parameter int unsigned n_boards   = 2,
  parameter int unsigned deb_frames = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [64*n_boards-1:0]  seg,
  input  logic [8*n_boards-1:0]   led,
  input  logic [2:0]              brightness,
  input  logic                    display_en,
  output logic [8*n_boards-1:0]   keys,
  output logic                    key_event,
  output logic                    frame_done,
  output logic                    sio_clk,
  output logic [n_boards-1:0]     sio_stb,
  input  logic                    sio_data_in,
  output logic                    sio_data_out,
  output logic                    sio_data_out_en
);

  localparam int unsigned hp = calc_hp(clk_mhz, sclk_khz);
  localparam int unsigned BW = (n_boards > 1) ? $clog2(n_boards) : 1;
  localparam int unsigned GW = $clog2(clk_mhz + 1);

  state_e         state_q, ret_q;
  logic [BW-1:0]  board_q;
  logic [GW-1:0]  gap_q;
  logic [4:0]     byte_q;
  logic           eng_start_q;
  logic [7:0]     eng_tx_q;
  logic           eng_busy, eng_done;
  logic [7:0]     eng_rx;
  logic [7:0]     raw_q, raw_next;
  logic [63:0]    snap_seg_q;
  logic [7:0]     snap_led_q;
  logic [2:0]     snap_bri_q;
  logic           snap_en_q;
  logic [n_boards-1:0] stb_sel;
  logic [7:0]     addr_byte;
  logic [7:0]     key_slice_next;
  logic [7:0]     keys_cur;
  logic [2:0]     digit;
  logic [1:0]     rd_inv;
  logic           unused_rx;

  assign unused_rx = ^{eng_rx[7:5], eng_rx[3:1]};
  assign keys_cur  = keys[8*board_q +: 8];

  tm1638_shift_engine #(
    .hp(hp)
  ) u_engine (
    .clk          (clk),
    .rst          (rst),
    .start        (eng_start_q),
    .tx_byte      (eng_tx_q),
    .busy         (eng_busy),
    .done         (eng_done),
    .rx_byte      (eng_rx),
    .sio_clk      (sio_clk),
    .sio_data_in  (sio_data_in),
    .sio_data_out (sio_data_out)
  );

  // Strobe pattern for the board currently being served.
  always_comb begin
    stb_sel          = '1;
    stb_sel[board_q] = 1'b0;
  end

  // Display data byte for the address stream: even = digit, odd = LED, highest digit first.
  always_comb begin
    digit     = ~byte_q[3:1];
    addr_byte = byte_q[0] ? {7'b0, snap_led_q[digit]} : snap_seg_q[{digit, 3'b000} +: 8];
  end

  // Merge the just-received key byte: bit0 -> key 7-i, bit4 -> key 3-i.
  always_comb begin
    rd_inv                    = ~byte_q[1:0];
    raw_next                  = raw_q;
    raw_next[{1'b1, rd_inv}]  = eng_rx[0];
    raw_next[{1'b0, rd_inv}]  = eng_rx[4];
  end

`ifdef TM1638_KEY_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(deb_frames + 1);

  logic [DW-1:0] deb_cnt_q [8*n_boards];
  logic [DW-1:0] deb_cnt_next [8];
  logic          key_apply;

  assign key_apply = (state_q == S_KEYRD) && eng_done && (byte_q == 5'd3);

  // A key flips only after deb_frames consecutive disagreeing scans.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      key_slice_next[k] = keys_cur[k];
      deb_cnt_next[k]   = '0;
      if (raw_next[k] != keys_cur[k]) begin
        if (deb_cnt_q[8*board_q + k] == DW'(deb_frames - 1)) begin
          key_slice_next[k] = raw_next[k];
        end else begin
          deb_cnt_next[k] = deb_cnt_q[8*board_q + k] + 1'b1;
        end
      end
    end
  end

  // Per-key debounce counters, updated only for the board just scanned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8*n_boards; i++) deb_cnt_q[i] <= '0;
    end else if (key_apply) begin
      for (int k = 0; k < 8; k++) deb_cnt_q[8*board_q + k] <= deb_cnt_next[k];
    end
  end
`else
  localparam int unsigned unused_deb_frames = deb_frames;
  assign key_slice_next = raw_next;
`endif

  // Command sequencer: strobes, gaps, byte scheduling, snapshot and key update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_GAP;
      ret_q           <= S_KEYCMD;
      board_q         <= '0;
      gap_q           <= '0;
      byte_q          <= 5'd0;
      eng_start_q     <= 1'b0;
      eng_tx_q        <= 8'h00;
      raw_q           <= 8'h00;
      snap_seg_q      <= 64'h0;
      snap_led_q      <= 8'h00;
      snap_bri_q      <= 3'd0;
      snap_en_q       <= 1'b0;
      sio_stb         <= '1;
      sio_data_out_en <= 1'b0;
      keys            <= '0;
      key_event       <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      eng_start_q     <= 1'b0;
      key_event       <= 1'b0;
      frame_done      <= 1'b0;
      sio_data_out_en <= 1'b1;
      case (state_q)
        S_GAP: begin
          sio_stb <= '1;
          if (gap_q == GW'(clk_mhz) && !eng_busy) begin
            gap_q       <= '0;
            state_q     <= ret_q;
            sio_stb     <= stb_sel;
            eng_start_q <= 1'b1;
            case (ret_q)
              S_MODE: begin
                eng_tx_q   <= C_WRITE_DISP;
                snap_seg_q <= seg[64*board_q +: 64];
                snap_led_q <= led[8*board_q +: 8];
                snap_bri_q <= brightness;
                snap_en_q  <= display_en;
              end
              S_ADDR: begin
                eng_tx_q <= C_SET_ADDR_0;
                byte_q   <= 5'd0;
              end
              S_CTRL: begin
                eng_tx_q <= snap_en_q ? (C_DISPLAY_BASE | {5'b0, snap_bri_q}) : C_DISPLAY_OFF;
              end
              default: eng_tx_q <= C_READ_KEYS;
            endcase
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        S_KEYCMD: begin
          if (eng_done) begin
            state_q         <= S_KEYRD;
            sio_data_out_en <= 1'b0;
            eng_start_q     <= 1'b1;
            eng_tx_q        <= 8'h00;
            byte_q          <= 5'd0;
            raw_q           <= 8'h00;
          end
        end
        S_KEYRD: begin
          if (eng_done) begin
            raw_q <= raw_next;
            if (byte_q == 5'd3) begin
              keys[8*board_q +: 8] <= key_slice_next;
              key_event            <= (key_slice_next != keys_cur);
              state_q              <= S_GAP;
              ret_q                <= S_MODE;
              sio_stb              <= '1;
            end else begin
              sio_data_out_en <= 1'b0;
              byte_q          <= byte_q + 5'd1;
              eng_start_q     <= 1'b1;
            end
          end else begin
            sio_data_out_en <= 1'b0;
          end
        end
        S_MODE: begin
          if (eng_done) begin
            state_q <= S_GAP;
            ret_q   <= S_ADDR;
            sio_stb <= '1;
          end
        end
        S_ADDR: begin
          if (eng_done) begin
            if (byte_q == 5'd16) begin
              state_q <= S_GAP;
              ret_q   <= S_CTRL;
              sio_stb <= '1;
            end else begin
              eng_tx_q    <= addr_byte;
              byte_q      <= byte_q + 5'd1;
              eng_start_q <= 1'b1;
            end
          end
        end
        S_CTRL: begin
          if (eng_done) begin
            state_q <= S_GAP;
            ret_q   <= S_KEYCMD;
            sio_stb <= '1;
            if (board_q == BW'(n_boards - 1)) begin
              board_q    <= '0;
              frame_done <= 1'b1;
            end else begin
              board_q <= board_q + 1'b1;
            end
          end
        end
        default: state_q <= S_GAP;
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_chain_controller.sv
// Directed bench for tm1638_chain_controller (n_boards=2, 50 MHz, 700 kHz -> hp=36).
module tb_tm1638_chain_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] seg;
  logic [15:0]  led;
  logic [2:0]   brightness;
  logic         display_en;
  logic [15:0]  keys;
  logic         key_event, frame_done;
  logic         sio_clk;
  logic [1:0]   sio_stb;
  logic         sio_data_in, sio_data_out, sio_data_out_en;

  bit         key_on;
  int         rdcnt;
  logic [7:0] wr_q[$];
  int         wr_board[$];
  logic [7:0] first8;
  int         nbits_total;
  int         ev_cnt, fd_cnt, viol;
  int         n_checks, n_errors;

  always #5 clk = ~clk;

  // Board 1 answers 0x01 in the first key byte, everything else reads 0.
  assign sio_data_in = key_on && !sio_stb[1] && !sio_data_out_en && (rdcnt == 0);

  tm1638_chain_controller dut (
    .clk             (clk),
    .rst             (rst),
    .seg             (seg),
    .led             (led),
    .brightness      (brightness),
    .display_en      (display_en),
    .keys            (keys),
    .key_event       (key_event),
    .frame_done      (frame_done),
    .sio_clk         (sio_clk),
    .sio_stb         (sio_stb),
    .sio_data_in     (sio_data_in),
    .sio_data_out    (sio_data_out),
    .sio_data_out_en (sio_data_out_en)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor: decodes written bytes LSB first, counts read bits and pulses.
  initial begin
    logic [7:0] sh;
    int bitcnt;
    logic prev_sclk;
    bitcnt = 0; prev_sclk = 1'b1; sh = 8'h00;
    rdcnt = 0; nbits_total = 0; first8 = 8'h00;
    ev_cnt = 0; fd_cnt = 0; viol = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bitcnt = 0; rdcnt = 0; prev_sclk = 1'b1;
      end else begin
        if (sio_stb == 2'b11) bitcnt = 0;
        if (sio_clk && !prev_sclk) begin
          if (sio_data_out_en) begin
            sh[bitcnt] = sio_data_out;
            if (nbits_total < 8) first8[nbits_total] = sio_data_out;
            nbits_total++;
            bitcnt++;
            if (bitcnt == 8) begin
              wr_q.push_back(sh);
              wr_board.push_back(sio_stb[0] ? 1 : 0);
              bitcnt = 0;
            end
          end else begin
            rdcnt++;
          end
        end
        if (sio_data_out_en) rdcnt = 0;
        prev_sclk = sio_clk;
        if (sio_stb == 2'b00) viol++;
        if (key_event) ev_cnt++;
        if (frame_done) fd_cnt++;
      end
    end
  end

  task automatic wait_bytes(input int n);
    int t = 0;
    while (wr_q.size() < n && t < 40000) begin
      @(posedge clk);
      t++;
    end
    if (wr_q.size() < n) check("wait_bytes_timeout", wr_q.size(), n);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;
    int base;
    logic [7:0] exp_bits;
    int   t_idx [12];
    logic [7:0] t_exp [12];
    n_checks = 0; n_errors = 0;
    rst = 1'b1; key_on = 1'b1;
    brightness = 3'd3; display_en = 1'b1;
    seg = '0; led = '0;
    seg[5*8 +: 8] = 8'h3F;
    led[5] = 1'b1;
    for (int k = 0; k < 8; k++) seg[64 + 8*k +: 8] = 8'h10 + 8'(k);
    led[15:8] = 8'hA5;

    repeat (3) @(posedge clk);
    #1;
    check("rst_stb", sio_stb, 2'b11);
    check("rst_sclk", sio_clk, 1'b1);
    check("rst_dout", sio_data_out, 1'b0);
    check("rst_dout_en", sio_data_out_en, 1'b0);
    check("rst_keys", keys, 16'h0000);
    check("rst_key_event", key_event, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (sio_stb[0] && n < 200);
    check("first_stb_delay", n, 51);
    check("first_stb_pattern", sio_stb, 2'b10);
    check("dout_en_after_rst", sio_data_out_en, 1'b1);

    t = 0;
    while (sio_clk && t < 200) begin @(posedge clk); #1; t++; end
    n = 1;
    do begin @(posedge clk); #1; if (!sio_clk) n++; end while (!sio_clk && n < 200);
    check("sclk_low_time", n, 36);

    wait_bytes(1);
    exp_bits = 8'h42;
    for (int i = 0; i < 8; i++) check($sformatf("cmd42_bit%0d", i), first8[i], exp_bits[i]);

    // Change digit 5 of board 0 after its snapshot: frame 1 keeps 0x3F.
    wait_bytes(3);
    @(negedge clk);
    seg[5*8 +: 8] = 8'h06;
    check("keys_before_board1", keys, 16'h0000);

    // Board 1 snapshot happens later, so its control byte sees display off.
    wait_bytes(20);
    @(negedge clk);
    display_en = 1'b0;

    t = 0;
    do begin @(posedge clk); #1; t++; end while (!key_event && t < 20000);
    check("key_event_seen", key_event, 1'b1);
    check("keys_board1", keys, 16'h8000);

    t = 0;
    do begin @(posedge clk); #1; t++; end while (!frame_done && t < 20000);
    check("frame_done_seen", frame_done, 1'b1);
    check("frame_done_bytes", wr_q.size(), 40);

    t_idx = '{0, 1, 2, 3, 4, 7, 8, 19, 22, 23, 24, 39};
    t_exp = '{8'h42, 8'h40, 8'hC0, 8'h00, 8'h00, 8'h3F, 8'h01, 8'h8B,
              8'hC0, 8'h17, 8'h01, 8'h80};
    for (int i = 0; i < 12; i++) check($sformatf("frame1_byte%0d", t_idx[i]), wr_q[t_idx[i]], t_exp[i]);
    check("board_of_byte20", wr_board[20], 1);

    wait_bytes(49);
    check("frame2_cmd", wr_q[40], 8'h42);
    check("frame2_board", wr_board[40], 0);
    check("frame2_digit5", wr_q[47], 8'h06);
    check("frame2_led5", wr_q[48], 8'h01);
    check("key_event_count", ev_cnt, 1);
    check("frame_done_count", fd_cnt, 1);
    check("stb_onehot_violations", viol, 0);

    // Reset in the middle of a data byte.
    t = 0;
    while (sio_clk && t < 200) begin @(posedge clk); #1; t++; end
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_stb", sio_stb, 2'b11);
    check("midrst_sclk", sio_clk, 1'b1);
    check("midrst_dout_en", sio_data_out_en, 1'b0);
    check("midrst_keys", keys, 16'h0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = wr_q.size();
    wait_bytes(base + 1);
    check("restart_cmd", wr_q[base], 8'h42);
    check("restart_board", wr_board[base], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
